ram_wb_arbiter: RTL and testbench

Round-robin Wishbone B3 arbiter that shares the single on-chip RAM slave (ram_wb) between up to four bus masters: CPU instruction bus, CPU data bus, debug-interface bus and an optional DMA/loader master. It sits between the masters and the RAM slave port in orpsoc_top. It holds a grant for the full length of a master's cycle, including B3 incrementing bursts, and routes slave responses only to the granted master.

---
 rtl/ram_wb_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_ram_wb_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_wb_arbiter
// Purpose  : Round-robin Wishbone B3 arbiter that shares one RAM slave
//            between up to four masters. A grant is held for the full
//            length of a master's cycle, bursts included, and slave
//            responses are steered only to the granted master.
// Optional : WB_ARB_WATCHDOG_EN - adds a stall watchdog that answers a hung
//            slave with a one-cycle err pulse to the granted master.
// Ports    : wb_clk_i, wb_rst_i       clock, synchronous active-high reset
//            wbm_*_i / wbm_*_o        packed master ports (master n = slice n)
//            wbs_*_o / wbs_*_i        RAM slave port
//            grant_o                  one-hot current grant (monitor only)
// Revision : 1.0 - initial release
// ============================================================================
module ram_wb_arbiter #(
   parameter int NUM_MASTERS = 3,
   parameter int dw          = 32,
   parameter int aw          = 32,
   parameter int TIMEOUT     = 255
) (
   input  logic                        wb_clk_i,
   input  logic                        wb_rst_i,
   // master side
   input  logic [NUM_MASTERS*aw-1:0]   wbm_adr_i,
   input  logic [NUM_MASTERS*dw-1:0]   wbm_dat_i,
   input  logic [NUM_MASTERS*dw/8-1:0] wbm_sel_i,
   input  logic [NUM_MASTERS-1:0]      wbm_we_i,
   input  logic [NUM_MASTERS-1:0]      wbm_cyc_i,
   input  logic [NUM_MASTERS-1:0]      wbm_stb_i,
   input  logic [NUM_MASTERS*3-1:0]    wbm_cti_i,
   input  logic [NUM_MASTERS*2-1:0]    wbm_bte_i,
   output logic [dw-1:0]               wbm_dat_o,
   output logic [NUM_MASTERS-1:0]      wbm_ack_o,
   output logic [NUM_MASTERS-1:0]      wbm_err_o,
   output logic [NUM_MASTERS-1:0]      wbm_rty_o,
   // slave side
   output logic [aw-1:0]               wbs_adr_o,
   output logic [dw-1:0]               wbs_dat_o,
   output logic [dw/8-1:0]             wbs_sel_o,
   output logic                        wbs_we_o,
   output logic                        wbs_cyc_o,
   output logic                        wbs_stb_o,
   output logic [2:0]                  wbs_cti_o,
   output logic [1:0]                  wbs_bte_o,
   input  logic [dw-1:0]               wbs_dat_i,
   input  logic                        wbs_ack_i,
   input  logic                        wbs_err_i,
   input  logic                        wbs_rty_i,
   // monitor
   output logic [NUM_MASTERS-1:0]      grant_o
);

   localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t                 state_q, state_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [IW-1:0]          gidx_q,  gidx_d;   // binary form of grant_q
   logic [IW-1:0]          last_q,  last_d;   // most recently released master

   logic                   busy;
   logic                   sel_cyc;
   logic                   sel_stb;
   logic                   pick_found;
   logic [IW-1:0]          pick_idx;
   logic [IW-1:0]          cand_idx;
   logic                   wd_fire;

   assign busy    = (state_q == ST_BUSY);
   assign sel_cyc = wbm_cyc_i[gidx_q];
   assign sel_stb = wbm_stb_i[gidx_q];

   // ------------------------------------------------------------------------
   // Arbitration and grant bookkeeping
   // ------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      gidx_d     = gidx_q;
      last_d     = last_q;
      pick_found = 1'b0;
      pick_idx   = last_q;
      cand_idx   = last_q;

      // Search upward from last+1 with wrap; last itself is checked last,
      // so a master cannot win twice in a row while another is waiting.
      for (int i = 1; i <= NUM_MASTERS; i++) begin
         cand_idx = IW'((int'(last_q) + i) % NUM_MASTERS);
         if (!pick_found && wbm_cyc_i[cand_idx]) begin
            pick_found = 1'b1;
            pick_idx   = cand_idx;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (pick_found) begin
               state_d           = ST_BUSY;
               grant_d           = '0;
               grant_d[pick_idx] = 1'b1;
               gidx_d            = pick_idx;
            end
         end
         ST_BUSY: begin
            // Only the owner dropping cyc ends the tenure; stb gaps and
            // burst boundaries keep the grant.
            if (!sel_cyc) begin
               state_d = ST_IDLE;
               grant_d = '0;
               last_d  = gidx_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         gidx_q  <= '0;
         last_q  <= IW'(NUM_MASTERS - 1);
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         gidx_q  <= gidx_d;
         last_q  <= last_d;
      end
   end

   assign grant_o = grant_q;

   // ------------------------------------------------------------------------
   // Stall watchdog
   // ------------------------------------------------------------------------
`ifdef WB_ARB_WATCHDOG_EN
   localparam int WD_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

   logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

   always_comb begin
      wd_cnt_d = wd_cnt_q;
      wd_fire  = 1'b0;
      if (!busy || !sel_cyc) begin
         wd_cnt_d = '0;
      end else if (wbs_ack_i || wbs_err_i || wbs_rty_i) begin
         wd_cnt_d = '0;
      end else if (sel_stb) begin
         // The TIMEOUT-th stalled cycle is the one that fires.
         if (wd_cnt_q == WD_W'(TIMEOUT - 1)) begin
            wd_fire  = 1'b1;
            wd_cnt_d = '0;
         end else begin
            wd_cnt_d = wd_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wd_cnt_q <= '0;
      end else begin
         wd_cnt_q <= wd_cnt_d;
      end
   end
`else
   localparam int unused_timeout = TIMEOUT;

   assign wd_fire = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Request path: granted master straight through to the slave
   // ------------------------------------------------------------------------
   always_comb begin
      wbs_adr_o = '0;
      wbs_dat_o = '0;
      wbs_sel_o = '0;
      wbs_we_o  = 1'b0;
      wbs_cyc_o = 1'b0;
      wbs_stb_o = 1'b0;
      wbs_cti_o = 3'b000;
      wbs_bte_o = 2'b00;
      if (busy) begin
         wbs_adr_o = wbm_adr_i[gidx_q*aw +: aw];
         wbs_dat_o = wbm_dat_i[gidx_q*dw +: dw];
         wbs_sel_o = wbm_sel_i[gidx_q*(dw/8) +: (dw/8)];
         wbs_we_o  = wbm_we_i[gidx_q];
         wbs_cyc_o = sel_cyc;
         // A watchdog timeout withdraws the strobe so the slave cannot
         // complete a beat that the master is being told has failed.
         wbs_stb_o = sel_stb & ~wd_fire;
         wbs_cti_o = wbm_cti_i[gidx_q*3 +: 3];
         wbs_bte_o = wbm_bte_i[gidx_q*2 +: 2];
      end
   end

   // ------------------------------------------------------------------------
   // Response path: grant_q is all-zero outside BUSY, so it doubles as the
   // response mask.
   // ------------------------------------------------------------------------
   assign wbm_dat_o = wbs_dat_i;
   assign wbm_ack_o = grant_q & {NUM_MASTERS{wbs_ack_i}};
   assign wbm_err_o = grant_q & {NUM_MASTERS{wbs_err_i | wd_fire}};
   assign wbm_rty_o = grant_q & {NUM_MASTERS{wbs_rty_i}};

endmodule
`default_nettype wire

// File: tb/tb_ram_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_wb_arbiter
// Purpose  : Self-checking bench for ram_wb_arbiter (3 masters). Directed
//            scenarios followed by randomized traffic against a behavioural
//            round-robin and memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_wb_arbiter;

   localparam int N  = 3;
   localparam int DW = 32;
   localparam int AW = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst;
   logic [N*AW-1:0]     m_adr;
   logic [N*DW-1:0]     m_dat;
   logic [N*DW/8-1:0]   m_sel;
   logic [N-1:0]        m_we, m_cyc, m_stb;
   logic [N*3-1:0]      m_cti;
   logic [N*2-1:0]      m_bte;
   logic [DW-1:0]       m_dat_o;
   logic [N-1:0]        m_ack, m_err, m_rty;
   logic [AW-1:0]       s_adr_o;
   logic [DW-1:0]       s_dat_o;
   logic [DW/8-1:0]     s_sel_o;
   logic                s_we_o, s_cyc_o, s_stb_o;
   logic [2:0]          s_cti_o;
   logic [1:0]          s_bte_o;
   logic [DW-1:0]       s_dat_i;
   logic                s_ack, s_err, s_rty;
   logic [N-1:0]        grant;

   int n_cmp = 0;
   int n_bad = 0;

   ram_wb_arbiter #(
      .NUM_MASTERS (N),
      .dw          (DW),
      .aw          (AW),
      .TIMEOUT     (16)
   ) dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .wbm_adr_i (m_adr),
      .wbm_dat_i (m_dat),
      .wbm_sel_i (m_sel),
      .wbm_we_i  (m_we),
      .wbm_cyc_i (m_cyc),
      .wbm_stb_i (m_stb),
      .wbm_cti_i (m_cti),
      .wbm_bte_i (m_bte),
      .wbm_dat_o (m_dat_o),
      .wbm_ack_o (m_ack),
      .wbm_err_o (m_err),
      .wbm_rty_o (m_rty),
      .wbs_adr_o (s_adr_o),
      .wbs_dat_o (s_dat_o),
      .wbs_sel_o (s_sel_o),
      .wbs_we_o  (s_we_o),
      .wbs_cyc_o (s_cyc_o),
      .wbs_stb_o (s_stb_o),
      .wbs_cti_o (s_cti_o),
      .wbs_bte_o (s_bte_o),
      .wbs_dat_i (s_dat_i),
      .wbs_ack_i (s_ack),
      .wbs_err_i (s_err),
      .wbs_rty_i (s_rty),
      .grant_o   (grant)
   );

   // ---------------- stimulus helpers (drive only) ----------------
   task automatic set_m(input int n, input logic cyc, input logic stb, input logic we,
                        input logic [31:0] adr, input logic [31:0] dat, input logic [2:0] cti);
      m_cyc[n]            = cyc;
      m_stb[n]            = stb;
      m_we[n]             = we;
      m_adr[n*AW +: AW]   = adr;
      m_dat[n*DW +: DW]   = dat;
      m_sel[n*4 +: 4]     = 4'hf;
      m_cti[n*3 +: 3]     = cti;
      m_bte[n*2 +: 2]     = 2'b00;
   endtask

   task automatic clear_all();
      for (int n = 0; n < N; n++) set_m(n, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
      s_dat_i = '0;
      s_ack   = 1'b0;
      s_err   = 1'b0;
      s_rty   = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench at posedge+1 with reset released and the DUT idle.
   task automatic do_reset();
      step();
      rst = 1'b1;
      clear_all();
      step();
      step();
      rst = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      do_reset();
      // idle masters with non-zero buses and a noisy slave must not leak
      set_m(0, 1'b0, 1'b0, 1'b1, 32'hdead_beef, 32'h1234_5678, 3'b111);
      s_ack = 1'b1; s_err = 1'b1; s_rty = 1'b1;
      @(negedge clk);
      n_cmp++; if (grant !== 3'b000) begin n_bad++; $display("FAIL reset_grant: got %b want 000", grant); end
      n_cmp++; if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b000) begin n_bad++; $display("FAIL reset_ctl: got %b want 000", {s_cyc_o, s_stb_o, s_we_o}); end
      n_cmp++; if ({s_adr_o, s_dat_o, s_sel_o} !== '0) begin n_bad++; $display("FAIL reset_bus: adr %h dat %h sel %h want 0", s_adr_o, s_dat_o, s_sel_o); end
      n_cmp++; if ({s_cti_o, s_bte_o} !== 5'b0) begin n_bad++; $display("FAIL reset_cti_bte: got %b want 00000", {s_cti_o, s_bte_o}); end
      n_cmp++; if ({m_ack, m_err, m_rty} !== '0) begin n_bad++; $display("FAIL reset_resp: ack %b err %b rty %b want 0", m_ack, m_err, m_rty); end
      clear_all();
   endtask

   task automatic test_single();
      logic [31:0] rd;
      do_reset();
      set_m(1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 3'b000);
      @(negedge clk);
      n_cmp++; if (grant !== 3'b000 || s_cyc_o !== 1'b0) begin n_bad++; $display("FAIL single_latency: grant %b cyc %b want 000/0", grant, s_cyc_o); end
      step();
      @(negedge clk);
      n_cmp++; if (grant !== 3'b010) begin n_bad++; $display("FAIL single_grant: got %b want 010", grant); end
      n_cmp++; if (s_cyc_o !== 1'b1 || s_stb_o !== 1'b1 || s_adr_o !== 32'h100 || s_we_o !== 1'b0) begin n_bad++; $display("FAIL single_req: cyc %b stb %b adr %h we %b", s_cyc_o, s_stb_o, s_adr_o, s_we_o); end
      step();
      rd = $urandom;
      s_dat_i = rd;
      s_ack = 1'b1;
      @(negedge clk);
      n_cmp++; if (m_ack !== 3'b010) begin n_bad++; $display("FAIL single_ack: got %b want 010", m_ack); end
      n_cmp++; if (m_dat_o !== rd) begin n_bad++; $display("FAIL single_data: got %h want %h", m_dat_o, rd); end
      step();
      s_ack = 1'b0;
      set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
      @(negedge clk);
      n_cmp++; if (s_cyc_o !== 1'b0 || m_ack !== 3'b000) begin n_bad++; $display("FAIL single_release: cyc %b ack %b want 0/000", s_cyc_o, m_ack); end
      step();
      @(negedge clk);
      n_cmp++; if (grant !== 3'b000) begin n_bad++; $display("FAIL single_idle: got %b want 000", grant); end
   endtask

   task automatic test_contention();
      logic [31:0] wd [N];
      do_reset();
      for (int n = 0; n < N; n++) begin
         wd[n] = $urandom;
         set_m(n, 1'b1, 1'b1, 1'b1, 32'h10 * (n + 1), wd[n], 3'b000);
      end
      for (int w = 0; w < N; w++) begin
         step();
         @(negedge clk);
         n_cmp++; if (grant !== 3'(1 << w)) begin n_bad++; $display("FAIL cont_grant%0d: got %b want %b", w, grant, 3'(1 << w)); end
         n_cmp++; if (s_dat_o !== wd[w] || s_we_o !== 1'b1) begin n_bad++; $display("FAIL cont_wdata%0d: got %h we %b want %h", w, s_dat_o, s_we_o, wd[w]); end
         s_ack = 1'b1;
         #1;
         n_cmp++; if (m_ack !== 3'(1 << w)) begin n_bad++; $display("FAIL cont_ack%0d: got %b want %b", w, m_ack, 3'(1 << w)); end
         step();
         s_ack = 1'b0;
         set_m(w, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
         @(negedge clk);
         n_cmp++; if (grant !== 3'(1 << w) || s_cyc_o !== 1'b0) begin n_bad++; $display("FAIL cont_release%0d: grant %b cyc %b", w, grant, s_cyc_o); end
         step();
         @(negedge clk);
         n_cmp++; if (grant !== 3'b000) begin n_bad++; $display("FAIL cont_gap%0d: got %b want 000", w, grant); end
      end
      step();
      set_m(0, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 3'b000);
      set_m(2, 1'b1, 1'b1, 1'b0, 32'h24, 32'h0, 3'b000);
      step();
      @(negedge clk);
      n_cmp++; if (grant !== 3'b001) begin n_bad++; $display("FAIL cont_repeat: got %b want 001", grant); end
      clear_all();
   endtask

   task automatic test_burst_hold();
      logic [31:0] rd;
      logic [2:0]  cti;
      do_reset();
      set_m(1, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 3'b010);
      step();
      set_m(0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 3'b000);
      for (int b = 0; b < 4; b++) begin
         cti = (b == 3) ? 3'b111 : 3'b010;
         set_m(1, 1'b1, 1'b1, 1'b0, 32'h200 + 32'(4 * b), 32'h0, cti);
         rd = $urandom;
         s_dat_i = rd;
         s_ack = 1'b1;
         @(negedge clk);
         n_cmp++; if (grant !== 3'b010 || m_ack !== 3'b010) begin n_bad++; $display("FAIL burst_beat%0d: grant %b ack %b want 010/010", b, grant, m_ack); end
         n_cmp++; if (s_adr_o !== 32'h200 + 32'(4 * b) || s_cti_o !== cti || m_dat_o !== rd) begin n_bad++; $display("FAIL burst_bus%0d: adr %h cti %b dat %h", b, s_adr_o, s_cti_o, m_dat_o); end
         step();
      end
      s_ack = 1'b0;
      set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
      @(negedge clk);
      n_cmp++; if (grant !== 3'b010 || s_cyc_o !== 1'b0) begin n_bad++; $display("FAIL burst_release: grant %b cyc %b", grant, s_cyc_o); end
      step();
      @(negedge clk);
      n_cmp++; if (grant !== 3'b000) begin n_bad++; $display("FAIL burst_gap: got %b want 000", grant); end
      step();
      @(negedge clk);
      n_cmp++; if (grant !== 3'b001 || s_adr_o !== 32'h40) begin n_bad++; $display("FAIL burst_next: grant %b adr %h want 001/40", grant, s_adr_o); end
      clear_all();
   endtask

   task automatic test_isolation();
      do_reset();
      set_m(2, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 3'b000);
      step();
      set_m(0, 1'b1, 1'b1, 1'b0, 32'h304, 32'h0, 3'b000);
      set_m(1, 1'b1, 1'b1, 1'b0, 32'h308, 32'h0, 3'b000);
      s_err = 1'b1;
      @(negedge clk);
      n_cmp++; if (grant !== 3'b100 || m_err !== 3'b100) begin n_bad++; $display("FAIL iso_err: grant %b err %b want 100/100", grant, m_err); end
      n_cmp++; if (m_ack !== 3'b000 || m_rty !== 3'b000) begin n_bad++; $display("FAIL iso_others: ack %b rty %b want 000", m_ack, m_rty); end
      step();
      s_err = 1'b0;
      s_rty = 1'b1;
      @(negedge clk);
      n_cmp++; if (m_rty !== 3'b100 || m_err !== 3'b000) begin n_bad++; $display("FAIL iso_rty: rty %b err %b want 100/000", m_rty, m_err); end
      clear_all();
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      set_m(0, 1'b1, 1'b1, 1'b0, 32'h400, 32'h0, 3'b010);
      step();
      s_ack = 1'b1;
      step();
      set_m(0, 1'b1, 1'b1, 1'b0, 32'h404, 32'h0, 3'b010);
      rst = 1'b1;
      step();
      rst = 1'b0;
      s_ack = 1'b0;
      set_m(1, 1'b1, 1'b1, 1'b0, 32'h500, 32'h0, 3'b000);
      @(negedge clk);
      n_cmp++; if (s_cyc_o !== 1'b0 || grant !== 3'b000) begin n_bad++; $display("FAIL rstmid_abandon: cyc %b grant %b want 0/000", s_cyc_o, grant); end
      step();
      @(negedge clk);
      n_cmp++; if (grant !== 3'b001) begin n_bad++; $display("FAIL rstmid_first: got %b want 001", grant); end
      clear_all();
   endtask

`ifdef WB_ARB_WATCHDOG_EN
   task automatic test_watchdog();
      logic fire;
      do_reset();
      set_m(0, 1'b1, 1'b1, 1'b0, 32'h600, 32'h0, 3'b000);
      step();
      for (int i = 1; i <= 20; i++) begin
         fire = (i == 16);
         @(negedge clk);
         n_cmp++; if (m_err[0] !== fire || s_stb_o !== !fire) begin n_bad++; $display("FAIL wd_cycle%0d: err %b stb %b want %b/%b", i, m_err[0], s_stb_o, fire, !fire); end
         step();
      end
      clear_all();
   endtask
`endif

   // Randomized traffic: masters issue single classic beats with random
   // gaps; the slave acks at random. The model tracks ownership from the
   // round-robin rules and data from the masters' own view of memory.
   task automatic test_random(input int cycles);
      logic [31:0] ref_mem [16];
      logic [31:0] slv_mem [16];
      logic [N-1:0] active;
      logic [N-1:0] cyc_snap;
      logic [N-1:0] exp_g;
      logic [N-1:0] exp_a;
      logic [3:0]   widx;
      int           gap [N];
      int           owner;
      int           last;
      int           acked;
      do_reset();
      for (int i = 0; i < 16; i++) begin ref_mem[i] = '0; slv_mem[i] = '0; end
      for (int n = 0; n < N; n++) gap[n] = 0;
      active = '0;
      owner = -1;
      last = N - 1;
      for (int c = 0; c < cycles; c++) begin
         for (int n = 0; n < N; n++) begin
            if (!active[n]) begin
               if (gap[n] > 0) gap[n]--;
               else if ($urandom_range(0, 1) == 1) begin
                  active[n] = 1'b1;
                  set_m(n, 1'b1, 1'b1, 1'($urandom_range(0, 1)),
                        {26'h0, 4'($urandom_range(0, 15)), 2'b00}, $urandom, 3'b000);
               end
            end
         end
         @(negedge clk);
         s_dat_i = $urandom;
         s_ack = 1'b0;
         if (s_cyc_o && s_stb_o && $urandom_range(0, 2) != 0) begin
            s_ack = 1'b1;
            if (s_we_o) slv_mem[s_adr_o[5:2]] = s_dat_o;
            else s_dat_i = slv_mem[s_adr_o[5:2]];
         end
         #1;
         exp_g = (owner >= 0) ? N'(1 << owner) : '0;
         exp_a = s_ack ? exp_g : '0;
         n_cmp++; if (grant !== exp_g) begin n_bad++; $display("FAIL rnd_grant c%0d: got %b want %b", c, grant, exp_g); end
         n_cmp++; if (m_ack !== exp_a) begin n_bad++; $display("FAIL rnd_ack c%0d: got %b want %b", c, m_ack, exp_a); end
         if (owner >= 0 && m_cyc[owner]) begin
            n_cmp++; if (s_cyc_o !== 1'b1 || s_adr_o !== m_adr[owner*AW +: AW]) begin n_bad++; $display("FAIL rnd_route c%0d: cyc %b adr %h want 1/%h", c, s_cyc_o, s_adr_o, m_adr[owner*AW +: AW]); end
         end else begin
            n_cmp++; if (s_cyc_o !== 1'b0) begin n_bad++; $display("FAIL rnd_idlecyc c%0d: got %b want 0", c, s_cyc_o); end
         end
         acked = -1;
         if (owner >= 0 && s_ack) begin
            acked = owner;
            widx = m_adr[owner*AW + 2 +: 4];
            if (m_we[owner]) ref_mem[widx] = m_dat[owner*DW +: DW];
            else begin
               n_cmp++; if (m_dat_o !== ref_mem[widx]) begin n_bad++; $display("FAIL rnd_rdata c%0d: got %h want %h", c, m_dat_o, ref_mem[widx]); end
            end
         end
         cyc_snap = m_cyc;
         @(posedge clk);
         if (owner < 0) begin
            for (int k = 1; k <= N; k++)
               if (owner < 0 && cyc_snap[(last + k) % N]) owner = (last + k) % N;
         end else if (!cyc_snap[owner]) begin
            last = owner;
            owner = -1;
         end
         #1;
         s_ack = 1'b0;
         if (acked >= 0) begin
            set_m(acked, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
            active[acked] = 1'b0;
            gap[acked] = $urandom_range(0, 3);
         end
      end
      clear_all();
   endtask

   initial begin
      rst = 1'b1;
      clear_all();
      test_reset();
      test_single();
      test_contention();
      test_burst_hold();
      test_isolation();
      test_reset_mid_burst();
`ifdef WB_ARB_WATCHDOG_EN
      test_watchdog();
`endif
      test_random(600);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL sim_timeout: bench did not finish within time limit");
      $fatal(1, "time limit");
   end

endmodule
`default_nettype wire
